// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage holding the program counter, a
// word-addressed instruction memory and the next-PC logic.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start             IDLE -> RUN request
//   prog_we/addr/data instruction-memory load port (IDLE only)
//   stall             freeze the stage for this cycle
//   branch_taken/_offset, jump/jump_target, jr/jr_addr
//                     redirect requests (priority jr > jump > branch)
//   instr, instr_pc, instr_pc4, instr_valid
//                     registered fetched word, its byte address, address+4
//   running, fault    FSM is in RUN / FAULT
//
// The fetch index is taken from pc[IDX_W+1:2], so ADDR_W must cover
// the whole memory (ADDR_W >= clog2(IMEM_DEPTH) + 2).
module fetch_unit #(
    parameter int              ADDR_W     = 32,
    parameter int              IMEM_DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [15:0]                   branch_offset,
    input  logic                          jump,
    input  logic [25:0]                   jump_target,
    input  logic                          jr,
    input  logic [ADDR_W-1:0]             jr_addr,
    output logic [31:0]                   instr,
    output logic [ADDR_W-1:0]             instr_pc,
    output logic [ADDR_W-1:0]             instr_pc4,
    output logic                          instr_valid,
    output logic                          running,
    output logic                          fault
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [31:0]         instr_q;
    logic [ADDR_W-1:0]   instr_pc_q;
    logic                instr_valid_q;
    logic                running_q;
    logic                fault_q;

    logic [31:0]         mem [IMEM_DEPTH];

    logic [ADDR_W-1:0]   pc4_d;
    logic [ADDR_W-1:0]   boff_ext_d;
    logic [ADDR_W-1:0]   br_target_d;
    logic [ADDR_W-1:0]   j_target_d;
    logic [ADDR_W-1:0]   redir_target_d;
    logic                redirect_d;
    logic                pc_bad_d;
    logic [17:0]         boff18;
    logic [27:0]         jt28;

    assign pc4_d = instr_pc_q + ADDR_W'(4);

    // Word offset -> byte offset, sign-extended (or truncated) to ADDR_W.
    assign boff18 = {branch_offset, 2'b00};
    always_comb begin
        boff_ext_d = '0;
        for (int i = 0; i < ADDR_W; i++)
            boff_ext_d[i] = (i < 18) ? boff18[i] : boff18[17];
    end

    assign br_target_d = pc4_d + boff_ext_d;

    assign jt28 = {jump_target, 2'b00};
    generate
        if (ADDR_W > 28) begin : g_jwide
            assign j_target_d = {pc4_d[ADDR_W-1:28], jt28};
        end else begin : g_jnarrow
            assign j_target_d = jt28[ADDR_W-1:0];
        end
    endgenerate

    // Redirects only act on a live instruction; during a bubble they are dropped.
    assign redirect_d = instr_valid_q & (jr | jump | branch_taken);

    always_comb begin
        redir_target_d = br_target_d;
        if (jr)        redir_target_d = jr_addr;
        else if (jump) redir_target_d = j_target_d;
    end

    // Misaligned or past the end of memory. One extra bit keeps the
    // compare exact when IMEM_DEPTH fills the whole address space.
    assign pc_bad_d = (pc_q[1:0] != 2'b00) ||
                      ((ADDR_W+1)'(pc_q >> 2) >= (ADDR_W+1)'(IMEM_DEPTH));

    // Memory is deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (reset && (state_q == S_IDLE) && prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            running_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pc_q <= RESET_PC;
                    if (start) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        // A redirect replaces the fall-through PC, so the
                        // range check applies only when nothing redirects.
                        if (redirect_d) begin
                            pc_q          <= redir_target_d;
                            instr_valid_q <= 1'b0;
                        end else if (pc_bad_d) begin
                            state_q       <= S_FAULT;
                            running_q     <= 1'b0;
                            fault_q       <= 1'b1;
                            instr_valid_q <= 1'b0;
                        end else begin
                            instr_q       <= mem[pc_q[IDX_W+1:2]];
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            pc_q          <= pc_q + ADDR_W'(4);
                        end
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    fault_q   <= 1'b0;
                end
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_pc4   = pc4_d;
    assign instr_valid = instr_valid_q;
    assign running     = running_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: load, run, stall, branch, jump/jr
// priority, fault entry and reset behaviour.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, prog_we, stall;
    logic [4:0]  prog_addr;
    logic [31:0] prog_data;
    logic        branch_taken, jump, jr;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] jr_addr;
    logic [31:0] instr, instr_pc, instr_pc4;
    logic        instr_valid, running, fault;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prog [8];

    fetch_unit #(.ADDR_W(32), .IMEM_DEPTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr),
        .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
        .instr_valid(instr_valid), .running(running), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        prog[0] = 32'h00622020; prog[1] = 32'h8C450BB8;
        prog[2] = 32'h1009000A; prog[3] = 32'h01A00008;
        prog[4] = 32'h24080005; prog[5] = 32'h24090007;
        prog[6] = 32'h240A0009; prog[7] = 32'h240B000B;

        reset = 1'b0; start = 1'b0; prog_we = 1'b0; stall = 1'b0;
        prog_addr = '0; prog_data = '0;
        branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; jr = 1'b0; jr_addr = '0;

        step(); step();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc",    instr_pc, 32'd0);
        chk("rst_run",   {31'b0, running}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);

        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prog_we = 1'b1; prog_addr = 5'(i); prog_data = prog[i];
            step();
        end
        prog_we = 1'b0;
        chk("idle_run", {31'b0, running}, 32'd0);

        start = 1'b1; step(); start = 1'b0;
        chk("start_run",   {31'b0, running}, 32'd1);
        chk("start_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("f0_valid", {31'b0, instr_valid}, 32'd1);
        chk("f0_instr", instr, prog[0]);
        chk("f0_pc",    instr_pc, 32'd0);
        chk("f0_pc4",   instr_pc4, 32'd4);
        step();
        chk("f1_instr", instr, prog[1]);
        chk("f1_pc",    instr_pc, 32'd4);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", instr, prog[1]);
            chk("stall_pc",    instr_pc, 32'd4);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk("f2_instr", instr, prog[2]);
        chk("f2_pc",    instr_pc, 32'd8);

        // Backward branch: 12 + (-2*4) = 4
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step(); branch_taken = 1'b0;
        chk("bb_bubble", {31'b0, instr_valid}, 32'd0);
        step();
        chk("bb_valid", {31'b0, instr_valid}, 32'd1);
        chk("bb_pc",    instr_pc, 32'd4);
        chk("bb_instr", instr, prog[1]);
        step();
        chk("bb_next_pc", instr_pc, 32'd8);

        // Forward branch: 12 + 2*4 = 20
        branch_taken = 1'b1; branch_offset = 16'h0002;
        step(); branch_taken = 1'b0;
        chk("bf_bubble", {31'b0, instr_valid}, 32'd0);
        step();
        chk("bf_pc",    instr_pc, 32'd20);
        chk("bf_instr", instr, prog[5]);
        chk("bf_pc4",   instr_pc4, 32'd24);

        // jr beats jump and branch
        jr = 1'b1; jr_addr = 32'h10; jump = 1'b1; jump_target = 26'h3;
        branch_taken = 1'b1; branch_offset = 16'h0002;
        step(); jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        chk("pri_bubble", {31'b0, instr_valid}, 32'd0);
        step();
        chk("pri_pc",    instr_pc, 32'h10);
        chk("pri_instr", instr, prog[4]);

        jump = 1'b1; jump_target = 26'h3;
        step(); jump = 1'b0;
        chk("j_bubble", {31'b0, instr_valid}, 32'd0);
        step();
        chk("j_pc",    instr_pc, 32'h0C);
        chk("j_instr", instr, prog[3]);

        // Reset while running with a live instruction
        reset = 1'b0; step();
        chk("mr_valid", {31'b0, instr_valid}, 32'd0);
        chk("mr_instr", instr, 32'd0);
        chk("mr_pc",    instr_pc, 32'd0);
        chk("mr_run",   {31'b0, running}, 32'd0);
        chk("mr_fault", {31'b0, fault}, 32'd0);
        reset = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("mr_resume_pc",    instr_pc, 32'd0);
        chk("mr_resume_instr", instr, prog[0]);
        step(); step();
        chk("mr_pc8", instr_pc, 32'd8);

        // Branch to byte 0x80 (index 32): 12 + 29*4
        branch_taken = 1'b1; branch_offset = 16'h001D;
        step(); branch_taken = 1'b0;
        chk("rf_pre_fault", {31'b0, fault}, 32'd0);
        step();
        chk("rf_fault", {31'b0, fault}, 32'd1);
        chk("rf_run",   {31'b0, running}, 32'd0);
        chk("rf_valid", {31'b0, instr_valid}, 32'd0);

        start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_fault", {31'b0, fault}, 32'd1);
            chk("fz_valid", {31'b0, instr_valid}, 32'd0);
        end
        start = 1'b0; prog_we = 1'b0;

        reset = 1'b0; step();
        chk("fr_fault", {31'b0, fault}, 32'd0);
        reset = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("keep_mem0", instr, prog[0]);

        // Misaligned jr target faults on the following edge
        jr = 1'b1; jr_addr = 32'h06;
        step(); jr = 1'b0;
        chk("jr6_fault1", {31'b0, fault}, 32'd0);
        chk("jr6_run1",   {31'b0, running}, 32'd1);
        chk("jr6_valid1", {31'b0, instr_valid}, 32'd0);
        step();
        chk("jr6_fault2", {31'b0, fault}, 32'd1);
        chk("jr6_run2",   {31'b0, running}, 32'd0);
        chk("jr6_valid2", {31'b0, instr_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
